// File: rtl/pkt_gen_pkg.sv
// Shared constants, types and the PRBS9 step function for the self-test
// frame generator.
package pkt_gen_pkg;

    localparam int LANES = 96;
    localparam int DW    = 9;

    typedef enum logic [1:0] {
        PKT_MODE_FIXED  = 2'd0,
        PKT_MODE_RAMP   = 2'd1,
        PKT_MODE_PRBS   = 2'd2,
        PKT_MODE_LANEID = 2'd3
    } pkt_mode_e;

    localparam logic [DW-1:0] PRBS9_SEED  = 9'h1FF;
    localparam int            PRBS9_TAP_A = 8;
    localparam int            PRBS9_TAP_B = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Burst configuration latched at start so mid-burst register writes are inert.
    typedef struct packed {
        pkt_mode_e     mode;
        logic [DW-1:0] fixed_val;
        logic [DW-1:0] step_val;
        logic [15:0]   len_val;
    } pkt_cfg_t;

    function automatic logic [DW-1:0] prbs9_adv(input logic [DW-1:0] s);
        return {s[DW-2:0], s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B]};
    endfunction

endpackage

// File: rtl/pkt_gen_data_if.sv
// Frame output bus of the pattern generator towards the ADC/test-data selector.
interface pkt_gen_data_if;
    import pkt_gen_pkg::*;

    logic [LANES*DW-1:0] pkt_gen_data;
    logic                pkt_gen_valid;
    logic                pkt_gen_busy;
    logic                pkt_gen_done;
    logic [15:0]         pkt_gen_frame_cnt;

    modport master (
        output pkt_gen_data, pkt_gen_valid, pkt_gen_busy, pkt_gen_done, pkt_gen_frame_cnt
    );
    modport slave (
        input  pkt_gen_data, pkt_gen_valid, pkt_gen_busy, pkt_gen_done, pkt_gen_frame_cnt
    );
endinterface

// File: rtl/pkt_gen_prbs9.sv
// Unrolls the PRBS9 LFSR across one frame: lane k gets the state after k
// advances from the seed, and next_seed is the state after LANES advances.
module pkt_gen_prbs9
    import pkt_gen_pkg::*;
(
    input  logic [DW-1:0]             seed,
    output logic [LANES-1:0][DW-1:0]  states,
    output logic [DW-1:0]             next_seed
);

    always_comb begin
        logic [DW-1:0] s;
        s = seed;
        for (int k = 0; k < LANES; k++) begin
            states[k] = s;
            s         = prbs9_adv(s);
        end
        next_seed = s;
    end

endmodule

// File: rtl/pkt_gen_data.sv
// Self-test frame generator: one 96-lane frame per clock in fixed, ramp,
// PRBS9 or lane-ID pattern, for a finite or continuous burst.
module pkt_gen_data
    import pkt_gen_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rf_self_mode,
    input  logic                 rf_pkt_start,
    input  logic [1:0]           rf_pkt_mode,
    input  logic [DW-1:0]        rf_pkt_fixed,
    input  logic [DW-1:0]        rf_pkt_step,
    input  logic [15:0]          rf_pkt_len,
    pkt_gen_data_if.master       out_if
);

    logic [1:0]                state_q, state_d;
    pkt_cfg_t                  cfg_q, cfg_d, cfg_in, cfg_g;
    logic [DW-1:0]             base_q, base_d, seed_q, seed_d;
    logic [DW-1:0]             g_base, g_seed, base_adv, seed_adv;
    logic [15:0]               cnt_q, cnt_d;
    logic [LANES*DW-1:0]       data_q, data_d;
    logic                      valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [LANES-1:0][DW-1:0]  frame, prbs_states;
    logic                      start_ok;

    assign start_ok = (state_q == ST_IDLE) && rf_self_mode && rf_pkt_start;
    assign cfg_in   = '{mode: pkt_mode_e'(rf_pkt_mode), fixed_val: rf_pkt_fixed,
                        step_val: rf_pkt_step, len_val: rf_pkt_len};

    // Frame 0 is registered on the start edge, so it is built from the live
    // inputs and reset seeds; later frames come from the shadow state.
    assign cfg_g    = start_ok ? cfg_in : cfg_q;
    assign g_base   = start_ok ? '0 : base_q;
    assign g_seed   = start_ok ? PRBS9_SEED : seed_q;
    assign base_adv = g_base + DW'(LANES) * cfg_g.step_val;

    pkt_gen_prbs9 u_prbs9 (
        .seed      (g_seed),
        .states    (prbs_states),
        .next_seed (seed_adv)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DW-1:0] ramp;
        assign ramp     = g_base + DW'(k) * cfg_g.step_val;
        assign frame[k] = (cfg_g.mode == PKT_MODE_FIXED) ? cfg_g.fixed_val :
                          (cfg_g.mode == PKT_MODE_RAMP)  ? ramp :
                          (cfg_g.mode == PKT_MODE_PRBS)  ? prbs_states[k] :
                                                           DW'(k);
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        base_d  = base_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        data_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    cfg_d   = cfg_in;
                    cnt_d   = '0;
                    base_d  = base_adv;
                    seed_d  = seed_adv;
                    data_d  = frame;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // The frame on the bus this cycle is counted on this edge.
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (!rf_self_mode) begin
                    state_d = ST_IDLE;
                end else if (cfg_q.len_val != 16'd0 && cnt_q == cfg_q.len_val - 16'd1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    base_d  = base_adv;
                    seed_d  = seed_adv;
                    data_d  = frame;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            base_q  <= '0;
            seed_q  <= PRBS9_SEED;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            base_q  <= base_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_if.pkt_gen_data      = data_q;
    assign out_if.pkt_gen_valid     = valid_q;
    assign out_if.pkt_gen_busy      = busy_q;
    assign out_if.pkt_gen_done      = done_q;
    assign out_if.pkt_gen_frame_cnt = cnt_q;

endmodule

// File: tb/tb_pkt_gen_data.sv
// Directed bench for pkt_gen_data: one task per scenario, hand-derived
// expected frames built by small local pattern functions.
module tb_pkt_gen_data;
    import pkt_gen_pkg::*;

    typedef logic [LANES*DW-1:0] frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_self_mode, rf_pkt_start;
    logic [1:0]  rf_pkt_mode;
    logic [8:0]  rf_pkt_fixed, rf_pkt_step;
    logic [15:0] rf_pkt_len;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pkt_gen_data_if gif ();

    pkt_gen_data dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rf_self_mode (rf_self_mode),
        .rf_pkt_start (rf_pkt_start),
        .rf_pkt_mode  (rf_pkt_mode),
        .rf_pkt_fixed (rf_pkt_fixed),
        .rf_pkt_step  (rf_pkt_step),
        .rf_pkt_len   (rf_pkt_len),
        .out_if       (gif)
    );

    function automatic frame_t exp_fixed(input logic [8:0] v);
        frame_t f;
        for (int k = 0; k < LANES; k++) f[k*DW +: DW] = v;
        return f;
    endfunction

    function automatic frame_t exp_ramp(input int base, input int step);
        frame_t f;
        for (int k = 0; k < LANES; k++) f[k*DW +: DW] = 9'((base + k*step) % 512);
        return f;
    endfunction

    function automatic frame_t exp_laneid();
        frame_t f;
        for (int k = 0; k < LANES; k++) f[k*DW +: DW] = 9'(k);
        return f;
    endfunction

    function automatic frame_t exp_prbs(input logic [8:0] seed, output logic [8:0] nxt);
        frame_t f;
        logic [8:0] s;
        s = seed;
        for (int k = 0; k < LANES; k++) begin
            f[k*DW +: DW] = s;
            s = ((s << 1) | {8'd0, s[8] ^ s[4]}) & 9'h1FF;
        end
        nxt = s;
        return f;
    endfunction

    function automatic logic [8:0] lane_of(input frame_t f, input int k);
        return f[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rf_self_mode = 1'b0; rf_pkt_start = 1'b0; rf_pkt_mode = 2'd0;
        rf_pkt_fixed = '0; rf_pkt_step = '0; rf_pkt_len = '0;
        tick(); tick();
        n_vec++; if (gif.pkt_gen_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", gif.pkt_gen_valid); end
        n_vec++; if (gif.pkt_gen_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", gif.pkt_gen_busy); end
        n_vec++; if (gif.pkt_gen_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", gif.pkt_gen_frame_cnt); end
        n_vec++; if (gif.pkt_gen_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", gif.pkt_gen_data); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_start();
        rf_self_mode = 1'b0; rf_pkt_start = 1'b1; rf_pkt_len = 16'd3;
        tick();
        rf_pkt_start = 1'b0;
        n_vec++; if (gif.pkt_gen_valid !== 1'b0) begin n_err++; $display("FAIL nostart_valid got %0b want 0", gif.pkt_gen_valid); end
        n_vec++; if (gif.pkt_gen_busy !== 1'b0) begin n_err++; $display("FAIL nostart_busy got %0b want 0", gif.pkt_gen_busy); end
        tick();
    endtask

    task automatic test_fixed();
        rf_self_mode = 1'b1; rf_pkt_mode = 2'd0; rf_pkt_fixed = 9'h155; rf_pkt_len = 16'd2;
        rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            n_vec++; if (gif.pkt_gen_valid !== 1'b1) begin n_err++; $display("FAIL fixed_valid f%0d got %0b want 1", n, gif.pkt_gen_valid); end
            n_vec++; if (gif.pkt_gen_busy !== 1'b1) begin n_err++; $display("FAIL fixed_busy f%0d got %0b want 1", n, gif.pkt_gen_busy); end
            n_vec++; if (gif.pkt_gen_data !== exp_fixed(9'h155)) begin n_err++; $display("FAIL fixed_data f%0d got %h want all 155", n, gif.pkt_gen_data); end
            n_vec++; if (gif.pkt_gen_frame_cnt !== 16'(n)) begin n_err++; $display("FAIL fixed_cnt f%0d got %0d want %0d", n, gif.pkt_gen_frame_cnt, n); end
            tick();
        end
        n_vec++; if (gif.pkt_gen_done !== 1'b1) begin n_err++; $display("FAIL fixed_done got %0b want 1", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_valid !== 1'b0) begin n_err++; $display("FAIL fixed_valid_end got %0b want 0", gif.pkt_gen_valid); end
        n_vec++; if (gif.pkt_gen_busy !== 1'b0) begin n_err++; $display("FAIL fixed_busy_end got %0b want 0", gif.pkt_gen_busy); end
        n_vec++; if (gif.pkt_gen_data !== '0) begin n_err++; $display("FAIL fixed_data_end got %h want 0", gif.pkt_gen_data); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd2) begin n_err++; $display("FAIL fixed_cnt_end got %0d want 2", gif.pkt_gen_frame_cnt); end
        tick();
        n_vec++; if (gif.pkt_gen_done !== 1'b0) begin n_err++; $display("FAIL fixed_done_pulse got %0b want 0", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd2) begin n_err++; $display("FAIL fixed_cnt_hold got %0d want 2", gif.pkt_gen_frame_cnt); end
    endtask

    task automatic test_ramp();
        rf_pkt_mode = 2'd1; rf_pkt_step = 9'd1; rf_pkt_len = 16'd6; rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            n_vec++; if (gif.pkt_gen_data !== exp_ramp(96*n, 1)) begin n_err++; $display("FAIL ramp_frame f%0d got %h want %h", n, gif.pkt_gen_data, exp_ramp(96*n, 1)); end
            if (n == 0) begin
                n_vec++; if (lane_of(gif.pkt_gen_data, 0) !== 9'd0) begin n_err++; $display("FAIL ramp_f0_l0 got %0d want 0", lane_of(gif.pkt_gen_data, 0)); end
                n_vec++; if (lane_of(gif.pkt_gen_data, 95) !== 9'd95) begin n_err++; $display("FAIL ramp_f0_l95 got %0d want 95", lane_of(gif.pkt_gen_data, 95)); end
            end
            if (n == 1) begin
                n_vec++; if (lane_of(gif.pkt_gen_data, 0) !== 9'd96) begin n_err++; $display("FAIL ramp_f1_l0 got %0d want 96", lane_of(gif.pkt_gen_data, 0)); end
            end
            if (n == 5) begin
                n_vec++; if (lane_of(gif.pkt_gen_data, 31) !== 9'd511) begin n_err++; $display("FAIL ramp_f5_l31 got %0d want 511", lane_of(gif.pkt_gen_data, 31)); end
                n_vec++; if (lane_of(gif.pkt_gen_data, 32) !== 9'd0) begin n_err++; $display("FAIL ramp_f5_l32 got %0d want 0", lane_of(gif.pkt_gen_data, 32)); end
            end
            tick();
        end
        n_vec++; if (gif.pkt_gen_done !== 1'b1) begin n_err++; $display("FAIL ramp_done got %0b want 1", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd6) begin n_err++; $display("FAIL ramp_cnt got %0d want 6", gif.pkt_gen_frame_cnt); end
        tick();
    endtask

    task automatic test_prbs();
        logic [8:0] s1, s2;
        frame_t e0, e1;
        e0 = exp_prbs(9'h1FF, s1);
        e1 = exp_prbs(s1, s2);
        rf_pkt_mode = 2'd2; rf_pkt_len = 16'd2; rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        n_vec++; if (lane_of(gif.pkt_gen_data, 0) !== 9'h1FF) begin n_err++; $display("FAIL prbs_l0 got %h want 1ff", lane_of(gif.pkt_gen_data, 0)); end
        n_vec++; if (lane_of(gif.pkt_gen_data, 1) !== 9'h1FE) begin n_err++; $display("FAIL prbs_l1 got %h want 1fe", lane_of(gif.pkt_gen_data, 1)); end
        n_vec++; if (lane_of(gif.pkt_gen_data, 2) !== 9'h1FC) begin n_err++; $display("FAIL prbs_l2 got %h want 1fc", lane_of(gif.pkt_gen_data, 2)); end
        n_vec++; if (gif.pkt_gen_data !== e0) begin n_err++; $display("FAIL prbs_frame0 got %h want %h", gif.pkt_gen_data, e0); end
        tick();
        n_vec++; if (lane_of(gif.pkt_gen_data, 0) !== s1) begin n_err++; $display("FAIL prbs_f1_l0 got %h want %h", lane_of(gif.pkt_gen_data, 0), s1); end
        n_vec++; if (gif.pkt_gen_data !== e1) begin n_err++; $display("FAIL prbs_frame1 got %h want %h", gif.pkt_gen_data, e1); end
        tick();
        n_vec++; if (gif.pkt_gen_done !== 1'b1) begin n_err++; $display("FAIL prbs_done got %0b want 1", gif.pkt_gen_done); end
        tick();
    endtask

    task automatic test_laneid_abort();
        rf_pkt_mode = 2'd3; rf_pkt_len = 16'd0; rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (gif.pkt_gen_valid !== 1'b1) begin n_err++; $display("FAIL lid_valid f%0d got %0b want 1", i, gif.pkt_gen_valid); end
            n_vec++; if (gif.pkt_gen_data !== exp_laneid()) begin n_err++; $display("FAIL lid_frame f%0d got %h want %h", i, gif.pkt_gen_data, exp_laneid()); end
            if (i < 9) tick();
        end
        rf_self_mode = 1'b0;
        tick();
        n_vec++; if (gif.pkt_gen_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %0b want 0", gif.pkt_gen_valid); end
        n_vec++; if (gif.pkt_gen_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %0b want 0", gif.pkt_gen_busy); end
        n_vec++; if (gif.pkt_gen_done !== 1'b0) begin n_err++; $display("FAIL abort_done got %0b want 0", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_data !== '0) begin n_err++; $display("FAIL abort_data got %h want 0", gif.pkt_gen_data); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd10) begin n_err++; $display("FAIL abort_cnt got %0d want 10", gif.pkt_gen_frame_cnt); end
        tick();
        n_vec++; if (gif.pkt_gen_done !== 1'b0) begin n_err++; $display("FAIL abort_done2 got %0b want 0", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd10) begin n_err++; $display("FAIL abort_cnt_hold got %0d want 10", gif.pkt_gen_frame_cnt); end
        rf_self_mode = 1'b1;
    endtask

    task automatic test_ignore_start();
        rf_pkt_mode = 2'd1; rf_pkt_step = 9'd2; rf_pkt_len = 16'd4; rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        n_vec++; if (gif.pkt_gen_data !== exp_ramp(0, 2)) begin n_err++; $display("FAIL ign_frame0 got %h want %h", gif.pkt_gen_data, exp_ramp(0, 2)); end
        rf_pkt_start = 1'b1; rf_pkt_step = 9'd5; rf_pkt_mode = 2'd3; rf_pkt_len = 16'd1;
        tick();
        rf_pkt_start = 1'b0;
        for (int n = 1; n < 4; n++) begin
            n_vec++; if (gif.pkt_gen_data !== exp_ramp(192*n, 2)) begin n_err++; $display("FAIL ign_frame%0d got %h want %h", n, gif.pkt_gen_data, exp_ramp(192*n, 2)); end
            tick();
        end
        n_vec++; if (gif.pkt_gen_done !== 1'b1) begin n_err++; $display("FAIL ign_done got %0b want 1", gif.pkt_gen_done); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd4) begin n_err++; $display("FAIL ign_cnt got %0d want 4", gif.pkt_gen_frame_cnt); end
        tick();
    endtask

    task automatic test_async_reset();
        rf_pkt_mode = 2'd0; rf_pkt_fixed = 9'h0AA; rf_pkt_len = 16'd0; rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        tick();
        n_vec++; if (gif.pkt_gen_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %0b want 1", gif.pkt_gen_valid); end
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (gif.pkt_gen_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0b want 0", gif.pkt_gen_valid); end
        n_vec++; if (gif.pkt_gen_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %0b want 0", gif.pkt_gen_busy); end
        n_vec++; if (gif.pkt_gen_data !== '0) begin n_err++; $display("FAIL arst_data got %h want 0", gif.pkt_gen_data); end
        n_vec++; if (gif.pkt_gen_frame_cnt !== 16'd0) begin n_err++; $display("FAIL arst_cnt got %0d want 0", gif.pkt_gen_frame_cnt); end
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        n_vec++; if (gif.pkt_gen_valid !== 1'b0) begin n_err++; $display("FAIL arst_idle_valid got %0b want 0", gif.pkt_gen_valid); end
        n_vec++; if (gif.pkt_gen_busy !== 1'b0) begin n_err++; $display("FAIL arst_idle_busy got %0b want 0", gif.pkt_gen_busy); end
        rf_pkt_start = 1'b1;
        tick();
        rf_pkt_start = 1'b0;
        n_vec++; if (gif.pkt_gen_data !== exp_fixed(9'h0AA)) begin n_err++; $display("FAIL arst_restart got %h want all 0aa", gif.pkt_gen_data); end
        rf_self_mode = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_no_start();
        test_fixed();
        test_ramp();
        test_prbs();
        test_laneid_abort();
        test_ignore_start();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
